// File: rtl/aes_stim_sequencer.sv
// aes_stim_sequencer: replays stored (plaintext, key, expected ciphertext)
// triples into an AES core one after another, checks every returned
// ciphertext against its expected value and keeps per-run pass/fail results.
module aes_stim_sequencer #(
  parameter int DATA_W  = 128,
  parameter int NUM_VEC = 4,
  parameter int TIMEOUT = 1024,
  parameter int GAP_W   = 8,
  localparam int AW = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1,
  localparam int CW = $clog2(NUM_VEC + 1)
) (
  input  logic              AES_clk,
  input  logic              AES_rst_n,
  // vector memory load port
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [DATA_W-1:0] wr_key,
  input  logic [DATA_W-1:0] wr_expect,
  // run control
  input  logic [CW-1:0]     num_run,
  input  logic [GAP_W-1:0]  gap_cycles,
  input  logic              start,
  // towards the AES core
  output logic              AES_en,
  output logic [DATA_W-1:0] AES_data_in,
  output logic [DATA_W-1:0] AES_key_in,
  // from the AES core
  input  logic [DATA_W-1:0] AES_data_out,
  input  logic              AES_data_out_valid,
  // status and results
  output logic              busy,
  output logic              done,
  output logic [CW-1:0]     pass_cnt,
  output logic [CW-1:0]     fail_cnt,
  output logic [AW-1:0]     first_fail_idx,
  output logic              fail_seen,
  output logic              timeout_seen
);

  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_GAP,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic [CW-1:0]     run_q, run_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic [TW-1:0]     wait_q, wait_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] key_q, key_d;
  logic [CW-1:0]     pass_cnt_q, pass_cnt_d;
  logic [CW-1:0]     fail_cnt_q, fail_cnt_d;
  logic [AW-1:0]     ffi_q, ffi_d;
  logic              fail_seen_q, fail_seen_d;
  logic              timeout_seen_q, timeout_seen_d;

  logic [DATA_W-1:0] vec_data_q [NUM_VEC];
  logic [DATA_W-1:0] vec_key_q  [NUM_VEC];
  logic [DATA_W-1:0] vec_exp_q  [NUM_VEC];

  logic              wr_ok;
  logic [AW-1:0]     idx_nxt;
  logic              last_vec;
  logic              vec_match;
  logic              fail_hit;
  logic [CW-1:0]     run_clamped;

  // Slot indices past the memory depth only exist when NUM_VEC is not a power of two.
  if ((2 ** AW) > NUM_VEC) begin : g_addr_chk
    assign wr_ok = (32'(wr_addr) < NUM_VEC);
  end else begin : g_addr_all
    assign wr_ok = 1'b1;
  end

  // A zero or oversized run request means "run every slot".
  assign run_clamped = (num_run == '0 || 32'(num_run) > NUM_VEC) ? CW'(NUM_VEC) : num_run;

  // Vector store: host writes land only while no run is in progress.
  // NOTE: the vector memory is deliberately not reset; it is plain storage the
  // host fills before a run, and leaving it unreset lets it map onto RAM.
  always_ff @(posedge AES_clk) begin
    if (wr_en && !busy && wr_ok) begin
      vec_data_q[wr_addr] <= wr_data;
      vec_key_q[wr_addr]  <= wr_key;
      vec_exp_q[wr_addr]  <= wr_expect;
    end
  end

  // Sequencer next-state logic: run setup, drive/compare, gap counting, wrap-up.
  always_comb begin
    // NOTE: every _d signal takes its hold value first, so no path through the
    // case statement can leave one unassigned and infer a latch.
    state_d        = state_q;
    idx_d          = idx_q;
    run_d          = run_q;
    gap_d          = gap_q;
    gap_cnt_d      = gap_cnt_q;
    wait_d         = wait_q;
    data_d         = data_q;
    key_d          = key_q;
    pass_cnt_d     = pass_cnt_q;
    fail_cnt_d     = fail_cnt_q;
    ffi_d          = ffi_q;
    fail_seen_d    = fail_seen_q;
    timeout_seen_d = timeout_seen_q;
    fail_hit       = 1'b0;
    idx_nxt        = idx_q + AW'(1);
    last_vec       = ((32'(idx_q) + 32'd1) == 32'(run_q));
    vec_match      = (AES_data_out == vec_exp_q[idx_q]);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          run_d          = run_clamped;
          gap_d          = gap_cycles;
          pass_cnt_d     = '0;
          fail_cnt_d     = '0;
          ffi_d          = '0;
          fail_seen_d    = 1'b0;
          timeout_seen_d = 1'b0;
          idx_d          = '0;
          wait_d         = '0;
          data_d         = vec_data_q[0];
          key_d          = vec_key_q[0];
          state_d        = S_DRIVE;
        end
      end

      S_DRIVE: begin
        wait_d = wait_q + TW'(1);
        // A response arriving on the timeout cycle still gets compared.
        if (AES_data_out_valid) begin
          if (vec_match) begin
            pass_cnt_d = pass_cnt_q + CW'(1);
          end else begin
            fail_hit = 1'b1;
          end
          gap_cnt_d = '0;
          state_d   = S_GAP;
        end else if (wait_q == TW'(TIMEOUT - 1)) begin
          fail_hit       = 1'b1;
          timeout_seen_d = 1'b1;
          gap_cnt_d      = '0;
          state_d        = S_GAP;
        end
      end

      S_GAP: begin
        // The GAP state always lasts gap_q+1 cycles, so gap 0 still gives one AES_en-low cycle.
        if (gap_cnt_q == gap_q) begin
          if (last_vec) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_nxt;
            data_d  = vec_data_q[idx_nxt];
            key_d   = vec_key_q[idx_nxt];
            wait_d  = '0;
            state_d = S_DRIVE;
          end
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (fail_hit) begin
      fail_cnt_d = fail_cnt_q + CW'(1);
      if (!fail_seen_q) begin
        fail_seen_d = 1'b1;
        ffi_d       = idx_q;
      end
    end
  end

  // Sequencer state and result registers; reset abandons any run in progress.
  // NOTE: clocked state uses non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge AES_clk or negedge AES_rst_n) begin
    if (!AES_rst_n) begin
      state_q        <= S_IDLE;
      idx_q          <= '0;
      run_q          <= '0;
      gap_q          <= '0;
      gap_cnt_q      <= '0;
      wait_q         <= '0;
      data_q         <= '0;
      key_q          <= '0;
      pass_cnt_q     <= '0;
      fail_cnt_q     <= '0;
      ffi_q          <= '0;
      fail_seen_q    <= 1'b0;
      timeout_seen_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      run_q          <= run_d;
      gap_q          <= gap_d;
      gap_cnt_q      <= gap_cnt_d;
      wait_q         <= wait_d;
      data_q         <= data_d;
      key_q          <= key_d;
      pass_cnt_q     <= pass_cnt_d;
      fail_cnt_q     <= fail_cnt_d;
      ffi_q          <= ffi_d;
      fail_seen_q    <= fail_seen_d;
      timeout_seen_q <= timeout_seen_d;
    end
  end

  assign AES_en         = (state_q == S_DRIVE);
  assign busy           = (state_q != S_IDLE);
  assign done           = (state_q == S_DONE);
  assign AES_data_in    = data_q;
  assign AES_key_in     = key_q;
  assign pass_cnt       = pass_cnt_q;
  assign fail_cnt       = fail_cnt_q;
  assign first_fail_idx = ffi_q;
  assign fail_seen      = fail_seen_q;
  assign timeout_seen   = timeout_seen_q;

endmodule

// File: tb/tb_aes_stim_sequencer.sv
// Testbench for aes_stim_sequencer: a behavioural AES stand-in answers each
// vector after a per-slot latency; a reference model predicts run results.
module tb_aes_stim_sequencer;

  localparam int NV = 4;
  localparam int TO = 16;
  localparam int DW = 128;

  logic          AES_clk;
  logic          AES_rst_n;
  logic          wr_en;
  logic [1:0]    wr_addr;
  logic [DW-1:0] wr_data, wr_key, wr_expect;
  logic [2:0]    num_run;
  logic [7:0]    gap_cycles;
  logic          start;
  logic          AES_en;
  logic [DW-1:0] AES_data_in, AES_key_in, AES_data_out;
  logic          AES_data_out_valid;
  logic          busy, done;
  logic [2:0]    pass_cnt, fail_cnt;
  logic [1:0]    first_fail_idx;
  logic          fail_seen, timeout_seen;

  aes_stim_sequencer #(.DATA_W(DW), .NUM_VEC(NV), .TIMEOUT(TO), .GAP_W(8)) dut (
    .AES_clk(AES_clk), .AES_rst_n(AES_rst_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_key(wr_key), .wr_expect(wr_expect),
    .num_run(num_run), .gap_cycles(gap_cycles), .start(start),
    .AES_en(AES_en), .AES_data_in(AES_data_in), .AES_key_in(AES_key_in),
    .AES_data_out(AES_data_out), .AES_data_out_valid(AES_data_out_valid),
    .busy(busy), .done(done), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
    .first_fail_idx(first_fail_idx), .fail_seen(fail_seen), .timeout_seen(timeout_seen)
  );

  initial AES_clk = 1'b0;
  always #5 AES_clk = ~AES_clk;

  int total = 0;
  int bad   = 0;

  // reference model state: what each slot holds and how fast the core answers it
  logic [DW-1:0] m_pt [NV];
  logic [DW-1:0] m_key[NV];
  logic [DW-1:0] m_exp[NV];
  int            lat  [NV];
  bit            spur;

  // monitor records
  int            rise_q[$];
  int            fall_q[$];
  logic [DW-1:0] seen_pt[$];
  logic [DW-1:0] seen_key[$];
  int            ncyc, en_len, slot, stab_err, done_cnt;
  bit            prev_en;
  logic [DW-1:0] hold_pt, hold_key;

  // stand-in cipher; any fixed bijection of (pt, key) serves for checking
  function automatic logic [DW-1:0] cipher(input logic [DW-1:0] pt, input logic [DW-1:0] k);
    return {pt[63:0], pt[127:64]} ^ k ^ 128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0;
  endfunction

  function automatic int drive_len(input int s);
    return (lat[s] > TO) ? TO : lat[s];
  endfunction

  // run-level prediction straight from the sequencing rules
  task automatic model_run(input int n_req, output int n, output int ep, output int ef,
                           output int effi, output bit efs, output bit eto);
    n = (n_req == 0 || n_req > NV) ? NV : n_req;
    ep = 0; ef = 0; effi = 0; efs = 0; eto = 0;
    for (int i = 0; i < n; i++) begin
      if (lat[i] <= TO && m_exp[i] == cipher(m_pt[i], m_key[i])) begin
        ep++;
      end else begin
        ef++;
        if (lat[i] > TO) eto = 1;
        if (!efs) begin efs = 1; effi = i; end
      end
    end
  endtask

  // AES stand-in and event monitor, evaluated on the falling edge
  initial begin
    AES_data_out_valid = 1'b0;
    AES_data_out = '0;
    ncyc = 0; stab_err = 0; done_cnt = 0; prev_en = 0; en_len = 0;
    forever begin
      @(negedge AES_clk);
      ncyc++;
      if (AES_en === 1'b1) begin
        if (!prev_en) begin
          rise_q.push_back(ncyc);
          seen_pt.push_back(AES_data_in);
          seen_key.push_back(AES_key_in);
          hold_pt = AES_data_in;
          hold_key = AES_key_in;
          en_len = 0;
        end
        en_len++;
        if (AES_data_in !== hold_pt || AES_key_in !== hold_key) stab_err++;
        slot = rise_q.size() - 1;
        if (slot < NV && en_len == lat[slot]) begin
          AES_data_out_valid = 1'b1;
          AES_data_out = cipher(AES_data_in, AES_key_in);
        end else begin
          AES_data_out_valid = 1'b0;
          AES_data_out = '0;
        end
      end else begin
        if (prev_en) fall_q.push_back(ncyc);
        AES_data_out_valid = spur && (busy === 1'b1);
        AES_data_out = cipher(hold_pt, hold_key);
      end
      if (done === 1'b1) done_cnt++;
      prev_en = (AES_en === 1'b1);
    end
  end

  task automatic load_slot(input int s, input bit corrupt, input int l);
    int b;
    m_pt[s]  = {$urandom, $urandom, $urandom, $urandom};
    m_key[s] = {$urandom, $urandom, $urandom, $urandom};
    m_exp[s] = cipher(m_pt[s], m_key[s]);
    if (corrupt) begin
      b = $urandom_range(DW - 1, 0);
      m_exp[s][b] = ~m_exp[s][b];
    end
    lat[s] = l;
    @(negedge AES_clk);
    wr_en = 1'b1; wr_addr = 2'(s);
    wr_data = m_pt[s]; wr_key = m_key[s]; wr_expect = m_exp[s];
    @(negedge AES_clk);
    wr_en = 1'b0;
  endtask

  task automatic start_run(input int n, input int g);
    @(negedge AES_clk);
    rise_q.delete(); fall_q.delete(); seen_pt.delete(); seen_key.delete();
    stab_err = 0;
    num_run = 3'(n); gap_cycles = 8'(g); start = 1'b1;
    @(negedge AES_clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int base;
    bit ok;
    base = done_cnt; ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge AES_clk); #1;
      if (done_cnt != base) ok = 1;
    end
    total++;
    if (!ok) begin bad++; $display("FAIL %s done_wait: no done within %0d cycles", name, budget); end
  endtask

  task automatic test_reset();
    AES_rst_n = 1'b0;
    repeat (3) @(negedge AES_clk);
    total++;
    if (AES_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL reset_ctrl en=%b busy=%b done=%b want 0 0 0", AES_en, busy, done);
    end
    total++;
    if (pass_cnt !== 3'd0 || fail_cnt !== 3'd0 || first_fail_idx !== 2'd0) begin
      bad++; $display("FAIL reset_cnt pass=%0d fail=%0d ffi=%0d want 0 0 0", pass_cnt, fail_cnt, first_fail_idx);
    end
    total++;
    if (fail_seen !== 1'b0 || timeout_seen !== 1'b0) begin
      bad++; $display("FAIL reset_flags fail_seen=%b timeout_seen=%b want 0 0", fail_seen, timeout_seen);
    end
    total++;
    if (AES_data_in !== '0 || AES_key_in !== '0) begin
      bad++; $display("FAIL reset_data data=%h key=%h want 0", AES_data_in, AES_key_in);
    end
    AES_rst_n = 1'b1;
  endtask

  task automatic test_single();
    int n, ep, ef, effi, dbase;
    bit efs, eto;
    load_slot(0, 1'b0, $urandom_range(TO, 1));
    model_run(1, n, ep, ef, effi, efs, eto);
    dbase = done_cnt;
    start_run(1, 3);
    total++;
    if (AES_en !== 1'b1 || busy !== 1'b1) begin
      bad++; $display("FAIL single_start en=%b busy=%b want 1 1", AES_en, busy);
    end
    wait_done("single", 200);
    total++;
    if (done !== 1'b1 || busy !== 1'b1) begin
      bad++; $display("FAIL single_done_cycle done=%b busy=%b want 1 1", done, busy);
    end
    total++;
    if (pass_cnt !== 3'(ep) || fail_cnt !== 3'(ef) || fail_seen !== efs) begin
      bad++; $display("FAIL single_result pass=%0d fail=%0d fs=%b want %0d %0d %b", pass_cnt, fail_cnt, fail_seen, ep, ef, efs);
    end
    total++;
    if (seen_pt.size() != 1 || fall_q.size() != 1) begin
      bad++; $display("FAIL single_drives got %0d want 1", seen_pt.size());
    end else if (seen_pt[0] !== m_pt[0] || seen_key[0] !== m_key[0] || fall_q[0] - rise_q[0] != lat[0] || stab_err != 0) begin
      bad++; $display("FAIL single_drive pt=%h len=%0d stab=%0d want pt=%h len=%0d stab=0",
                      seen_pt[0], fall_q[0] - rise_q[0], stab_err, m_pt[0], lat[0]);
    end
    @(negedge AES_clk);
    total++;
    if (done !== 1'b0 || busy !== 1'b0 || done_cnt != dbase + 1) begin
      bad++; $display("FAIL single_end done=%b busy=%b pulses=%0d want 0 0 1", done, busy, done_cnt - dbase);
    end
  endtask

  task automatic test_corrupt_gap();
    for (int i = 0; i < NV; i++) load_slot(i, (i == 2), $urandom_range(TO, 1));
    start_run(4, 15);
    wait_done("corrupt_gap", 400);
    total++;
    if (pass_cnt !== 3'd3 || fail_cnt !== 3'd1 || first_fail_idx !== 2'd2 || fail_seen !== 1'b1 || timeout_seen !== 1'b0) begin
      bad++; $display("FAIL corrupt_result pass=%0d fail=%0d ffi=%0d fs=%b to=%b want 3 1 2 1 0",
                      pass_cnt, fail_cnt, first_fail_idx, fail_seen, timeout_seen);
    end
    total++;
    if (rise_q.size() != 4 || fall_q.size() != 4) begin
      bad++; $display("FAIL corrupt_drives got %0d want 4", rise_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        total++;
        if (rise_q[i+1] - fall_q[i] != 16) begin
          bad++; $display("FAIL corrupt_gap_len[%0d] got %0d want 16", i, rise_q[i+1] - fall_q[i]);
        end
      end
      for (int i = 0; i < 4; i++) begin
        total++;
        if (seen_pt[i] !== m_pt[i] || fall_q[i] - rise_q[i] != lat[i]) begin
          bad++; $display("FAIL corrupt_drive[%0d] pt=%h len=%0d want %h %0d", i, seen_pt[i], fall_q[i] - rise_q[i], m_pt[i], lat[i]);
        end
      end
    end
  endtask

  task automatic test_timeout();
    load_slot(0, 1'b0, 1000);
    load_slot(1, 1'b0, 1000);
    start_run(2, 2);
    wait_done("timeout", 200);
    total++;
    if (pass_cnt !== 3'd0 || fail_cnt !== 3'd2 || timeout_seen !== 1'b1 || first_fail_idx !== 2'd0 || fail_seen !== 1'b1) begin
      bad++; $display("FAIL timeout_result pass=%0d fail=%0d to=%b ffi=%0d want 0 2 1 0", pass_cnt, fail_cnt, timeout_seen, first_fail_idx);
    end
    total++;
    if (fall_q.size() != 2 || fall_q[0] - rise_q[0] != TO || fall_q[1] - rise_q[1] != TO) begin
      bad++; $display("FAIL timeout_len drives=%0d want 2 of %0d cycles", fall_q.size(), TO);
    end
    // valid on the very last allowed cycle still compares; one cycle later is a timeout
    load_slot(0, 1'b0, TO);
    load_slot(1, 1'b0, TO + 1);
    start_run(2, 0);
    wait_done("timeout_edge", 200);
    total++;
    if (pass_cnt !== 3'd1 || fail_cnt !== 3'd1 || timeout_seen !== 1'b1 || first_fail_idx !== 2'd1) begin
      bad++; $display("FAIL timeout_edge pass=%0d fail=%0d to=%b ffi=%0d want 1 1 1 1", pass_cnt, fail_cnt, timeout_seen, first_fail_idx);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < NV; i++) load_slot(i, 1'b0, $urandom_range(4, 1));
    start_run(0, 0);
    wait_done("back_to_back", 200);
    total++;
    if (pass_cnt !== 3'd4 || fail_cnt !== 3'd0 || timeout_seen !== 1'b0 || fail_seen !== 1'b0) begin
      bad++; $display("FAIL b2b_result pass=%0d fail=%0d to=%b fs=%b want 4 0 0 0", pass_cnt, fail_cnt, timeout_seen, fail_seen);
    end
    total++;
    if (rise_q.size() != 4 || fall_q.size() != 4) begin
      bad++; $display("FAIL b2b_drives got %0d want 4", rise_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        total++;
        if (rise_q[i+1] - fall_q[i] != 1) begin
          bad++; $display("FAIL b2b_gap[%0d] got %0d want 1", i, rise_q[i+1] - fall_q[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int dbase;
    bit ok;
    for (int i = 0; i < NV; i++) load_slot(i, 1'b0, 6);
    start_run(4, 2);
    ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge AES_clk); #1;
      if (rise_q.size() >= 2) ok = 1;
    end
    total++;
    if (!ok) begin bad++; $display("FAIL rstmid_reach: vector 1 not driven within 100 cycles"); end
    @(negedge AES_clk);
    total++;
    if (AES_en !== 1'b1 || pass_cnt !== 3'd1) begin
      bad++; $display("FAIL rstmid_pre en=%b pass=%0d want 1 1", AES_en, pass_cnt);
    end
    dbase = done_cnt;
    #2 AES_rst_n = 1'b0;
    #1;
    total++;
    if (AES_en !== 1'b0 || busy !== 1'b0 || pass_cnt !== 3'd0 || fail_cnt !== 3'd0 || AES_data_in !== '0) begin
      bad++; $display("FAIL rstmid_async en=%b busy=%b pass=%0d fail=%0d data=%h want 0 0 0 0 0",
                      AES_en, busy, pass_cnt, fail_cnt, AES_data_in);
    end
    repeat (10) @(negedge AES_clk);
    AES_rst_n = 1'b1;
    repeat (20) @(negedge AES_clk);
    total++;
    if (done_cnt != dbase || busy !== 1'b0) begin
      bad++; $display("FAIL rstmid_nodone pulses=%0d busy=%b want 0 0", done_cnt - dbase, busy);
    end
    start_run(4, 2);
    wait_done("reset_mid_rerun", 300);
    total++;
    if (pass_cnt !== 3'd4 || rise_q.size() != 4 || seen_pt[0] !== m_pt[0]) begin
      bad++; $display("FAIL rstmid_rerun pass=%0d drives=%0d want 4 4", pass_cnt, rise_q.size());
    end
  endtask

  task automatic test_busy_ignore();
    logic [DW-1:0] old_pt1;
    load_slot(0, 1'b0, 5);
    load_slot(1, 1'b0, 5);
    old_pt1 = m_pt[1];
    start_run(2, 10);
    wr_en = 1'b1; wr_addr = 2'd1; wr_data = ~m_pt[1]; wr_key = ~m_key[1]; wr_expect = '0;
    start = 1'b1; num_run = 3'd1;
    @(negedge AES_clk);
    wr_en = 1'b0; start = 1'b0;
    spur = 1'b1;
    wait_done("busy_ignore", 200);
    spur = 1'b0;
    total++;
    if (rise_q.size() != 2 || pass_cnt !== 3'd2 || fail_cnt !== 3'd0) begin
      bad++; $display("FAIL busy_run drives=%0d pass=%0d fail=%0d want 2 2 0", rise_q.size(), pass_cnt, fail_cnt);
    end
    start_run(2, 0);
    wait_done("busy_mem", 200);
    total++;
    if (seen_pt.size() != 2 || seen_pt[1] !== old_pt1 || seen_key[1] !== m_key[1] || pass_cnt !== 3'd2) begin
      bad++; $display("FAIL busy_mem drives=%0d pass=%0d slot1 pt=%h want pt=%h", seen_pt.size(), pass_cnt,
                      (seen_pt.size() > 1) ? seen_pt[1] : '0, old_pt1);
    end
  endtask

  task automatic test_random();
    int n, ep, ef, effi, n_req, g;
    bit efs, eto;
    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < NV; i++) load_slot(i, ($urandom_range(3, 0) == 0), $urandom_range(TO + 2, 1));
      n_req = $urandom_range(7, 0);
      g = $urandom_range(5, 0);
      model_run(n_req, n, ep, ef, effi, efs, eto);
      start_run(n_req, g);
      wait_done("random", 400);
      total++;
      if (pass_cnt !== 3'(ep) || fail_cnt !== 3'(ef) || fail_seen !== efs || timeout_seen !== eto) begin
        bad++; $display("FAIL rand%0d_result pass=%0d fail=%0d fs=%b to=%b want %0d %0d %b %b",
                        it, pass_cnt, fail_cnt, fail_seen, timeout_seen, ep, ef, efs, eto);
      end
      if (efs) begin
        total++;
        if (first_fail_idx !== 2'(effi)) begin
          bad++; $display("FAIL rand%0d_ffi got %0d want %0d", it, first_fail_idx, effi);
        end
      end
      total++;
      if (rise_q.size() != n || fall_q.size() != n) begin
        bad++; $display("FAIL rand%0d_drives got %0d want %0d", it, rise_q.size(), n);
      end else begin
        for (int i = 0; i < n; i++) begin
          total++;
          if (seen_pt[i] !== m_pt[i] || seen_key[i] !== m_key[i] || fall_q[i] - rise_q[i] != drive_len(i) ||
              (i < n - 1 && rise_q[i+1] - fall_q[i] != g + 1)) begin
            bad++; $display("FAIL rand%0d_vec[%0d] len=%0d want %0d gap=%0d", it, i, fall_q[i] - rise_q[i], drive_len(i), g);
          end
        end
      end
    end
  endtask

  initial begin
    AES_rst_n = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_key = '0; wr_expect = '0;
    num_run = '0; gap_cycles = '0; start = 1'b0; spur = 1'b0;
    for (int i = 0; i < NV; i++) lat[i] = 1;
    test_reset();
    test_single();
    test_corrupt_gap();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    test_busy_ignore();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
